// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared word/byte types and fetch FSM state encoding
package common_pkg;

   typedef logic [15:0] word_t;
   typedef logic [7:0]  mem_data_t;
   typedef logic [15:0] mem_addr_t;

   localparam word_t RESET_PC_DEFAULT = 16'o001000;

   typedef enum logic [2:0] {
      IDLE,
      FETCH_LO,
      FETCH_HI,
      HOLD,
      ERR
   } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - byte-wide instruction fetch, assembles little-endian 16-bit words
module inst_fetch_unit
   import common_pkg::*;
#(
   parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      run,
   input  logic      redir_valid,
   input  word_t     redir_pc,
   output logic      mem_req,
   output mem_addr_t mem_addr,
   input  logic      mem_ack,
   input  mem_data_t mem_rdata,
   output logic      iw_valid,
   output word_t     iw_data,
   output word_t     iw_pc,
   input  logic      iw_ready,
   output logic      align_err
);

   fetch_state_t state;
   word_t        pc;
   logic         flush;

   logic         fetching;
   logic         abandon;
   logic         release_word;
   logic         start;
   word_t        start_pc;

   // abandon: an acked byte that belongs to a superseded fetch stream
   always_comb begin
      fetching     = (state == FETCH_LO) || (state == FETCH_HI);
      abandon      = fetching && mem_ack && (redir_valid || flush);
      release_word = (state == HOLD) && (redir_valid || iw_ready);
      start        = run && ((state == IDLE) || abandon || release_word);
      start_pc     = redir_valid ? redir_pc : pc;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         flush     <= 1'b0;
         iw_data   <= '0;
         iw_pc     <= '0;
         iw_valid  <= 1'b0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         align_err <= 1'b0;
      end else if (start) begin
         pc       <= start_pc;
         flush    <= 1'b0;
         iw_valid <= 1'b0;
         if (start_pc[0]) begin
            state     <= ERR;
            align_err <= 1'b1;
            mem_req   <= 1'b0;
         end else begin
            state    <= FETCH_LO;
            mem_req  <= 1'b1;
            mem_addr <= start_pc;
         end
      end else if (abandon || release_word) begin
         pc       <= start_pc;
         flush    <= 1'b0;
         iw_valid <= 1'b0;
         mem_req  <= 1'b0;
         state    <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (redir_valid) pc <= redir_pc;
            end
            FETCH_LO: begin
               // request stays up on the old address until its ack arrives
               if (redir_valid) begin
                  pc    <= redir_pc;
                  flush <= 1'b1;
               end else if (mem_ack) begin
                  iw_data[7:0] <= mem_rdata;
                  mem_addr     <= pc + 16'd1;
                  state        <= FETCH_HI;
               end
            end
            FETCH_HI: begin
               if (redir_valid) begin
                  pc    <= redir_pc;
                  flush <= 1'b1;
               end else if (mem_ack) begin
                  iw_data[15:8] <= mem_rdata;
                  iw_pc         <= pc;
                  pc            <= pc + 16'd2;
                  iw_valid      <= 1'b1;
                  mem_req       <= 1'b0;
                  state         <= HOLD;
               end
            end
            HOLD: ;
            ERR:  ;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
